nibble_serial_adder: RTL



---
 rtl/adder_pkg.sv | 21 ++
 rtl/bk_nibble_add.sv | 46 ++++
 rtl/nibble_serial_adder.sv | 106 ++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM states
// and the step-counter sizing helper.
package adder_pkg;

  // Width of the shared adder slice; operands are consumed this many bits per step.
  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter width: ceil(log2(WIDTH/NIBBLE)), but never narrower than one bit.
  function automatic int cnt_width(input int width);
    int steps;
    steps = width / NIBBLE;
    return (steps <= 2) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/bk_nibble_add.sv
// Combinational 4-bit Brent-Kung adder slice with carry in and carry out.
module bk_nibble_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic       g10, p10;
  logic       g32, p32;
  logic       g30, p30;
  logic       g20, p20;
  logic [3:0] carry;

  // Bit-level generate/propagate, then the prefix tree and sum bits.
  always_comb begin
    g = a & b;
    p = a ^ b;

    // Pairwise groups.
    g10 = g[1] | (p[1] & g[0]);
    p10 = p[1] & p[0];
    g32 = g[3] | (p[3] & g[2]);
    p32 = p[3] & p[2];

    // Full group (3:0) from the two pairs.
    g30 = g32 | (p32 & g10);
    p30 = p32 & p10;

    // Fill-in group (2:0) feeding the carry into bit 3.
    g20 = g[2] | (p[2] & g10);
    p20 = p[2] & p10;

    carry[0] = cin;
    carry[1] = g[0] | (p[0] & cin);
    carry[2] = g10  | (p10  & cin);
    carry[3] = g20  | (p20  & cin);

    s    = p ^ carry;
    cout = g30 | (p30 & cin);
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that pushes the operands through one 4-bit slice, one
// nibble per clock, with valid/ready handshakes on both sides.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int STEPS = WIDTH / NIBBLE;
  localparam int CW    = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  state_t                  state, state_next;
  logic [WIDTH-1:0]        a_reg, b_reg, sum_reg;
  logic                    carry_reg;
  logic [CW-1:0]           step;
  logic [NIBBLE-1:0]       slice_s;
  logic                    slice_cout;
  // Slice result prepended to the sum register; the upper WIDTH bits are the
  // shifted-right sum with the new nibble at the top (works for WIDTH == 4 too).
  logic [WIDTH+NIBBLE-1:0] sum_ext;

  bk_nibble_add u_slice (
    .a    (a_reg[NIBBLE-1:0]),
    .b    (b_reg[NIBBLE-1:0]),
    .cin  (carry_reg),
    .s    (slice_s),
    .cout (slice_cout)
  );

  assign sum_ext = {slice_s, sum_reg};

  // State register.
  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: accept in IDLE, step through RUN, hold in DONE until taken.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)          state_next = RUN;
      RUN:     if (step == LAST_STEP) state_next = DONE;
      DONE:    if (out_ready)         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on acceptance, then one nibble per RUN edge.
  // NOTE: every datapath register is reset so sum/cout read zero after reset
  // and an aborted operation leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      step      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            step      <= '0;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> NIBBLE;
          b_reg     <= b_reg >> NIBBLE;
          sum_reg   <= sum_ext[WIDTH+NIBBLE-1:NIBBLE];
          carry_reg <= slice_cout;
          // Hold at the last step rather than wrapping; the FSM leaves RUN here.
          if (step != LAST_STEP) step <= step + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_reg;
  assign cout      = carry_reg;

endmodule
